maze_round_timer: RTL and testbench
===================================

// Module: maze_round_timer
// PURPOSE
//   Per-round countdown timer for the maze game. Drives the timer_end input of the game top-level.
//   Counts whole seconds down from ROUND_SECONDS and awards BONUS_SECONDS on every completed maze.
//   Asserts timer_end when time runs out and exposes BCD digits for the seven-segment display.
// PARAMETERS
//   CLOCK_FREQ     50_000_000  clock cycles per second; the prescaler terminal count is CLOCK_FREQ-1
//   ROUND_SECONDS  60          value loaded on start; must be 1..MAX_SECONDS
//   BONUS_SECONDS  10          seconds added per completed maze
//   MAX_SECONDS    99          saturation ceiling; must be <=99 (two BCD digits)
// PORTS
//   clock           in   1  system clock; all logic is on posedge
//   reset           in   1  synchronous, active-low reset
//   start           in   1  one-cycle pulse: load ROUND_SECONDS and run
//   mazes_complete  in   8  completed-maze count from the game top-level (same clock domain)
//   timer_end       out  1  high while state==EXPIRED
//   running         out  1  high while state==RUNNING
//   seconds_left    out  7  remaining seconds, binary
//   seconds_tens    out  4  BCD tens digit of seconds_left
//   seconds_ones    out  4  BCD ones digit of seconds_left
//   second_tick     out  1  one-cycle pulse on every prescaler wrap while RUNNING
//   pause           in   1  present only with TIMER_PAUSE_EN
// BEHAVIOUR
//   Reset (reset==0 at a clock edge): state=IDLE, seconds_left=0, prescaler=0, timer_end=0, running=0.
//     second_tick=0; mazes_prev is loaded with mazes_complete so no bonus fires after reset.
//     Reset mid-round aborts the round with no residual pulses.
//   FSM:
//     IDLE    -start-> RUNNING.
//     RUNNING -seconds_left reaches 0-> EXPIRED.
//     EXPIRED -start-> RUNNING.
//     start while RUNNING reloads the count (restart).
//   Load: on start, seconds_left=ROUND_SECONDS and prescaler=0. Start has priority over tick and bonus that cycle.
//   Prescaler: increments only in RUNNING. At CLOCK_FREQ-1 it wraps to 0, and second_tick is asserted
//     the following cycle, together with the decremented seconds_left.
//   Bonus: a bonus event is any cycle where mazes_complete != mazes_prev; mazes_prev updates every cycle.
//     8-bit wrap 255->0 is still a change. Bonus is applied in RUNNING only and ignored in IDLE/EXPIRED.
//   Update arithmetic: next = seconds_left - tick + (bonus ? BONUS_SECONDS : 0), computed 8 bits wide,
//     then saturated to MAX_SECONDS.
//   Tick and bonus in the same cycle: both apply. If next==0, go to EXPIRED; if next>0, stay RUNNING.
//   EXPIRED: seconds_left holds 0; timer_end stays high until start or reset.
//   Latency: all outputs are registered, one cycle after the causing edge.
//   BCD digits are derived combinationally from the registered seconds_left: tens=seconds_left/10, ones=seconds_left%10.
// CONFIGURATION
//   TIMER_PAUSE_EN defined:
//     The pause port exists. While pause==1 in RUNNING, the prescaler freezes, no ticks occur and bonuses still apply.
//     Start overrides pause.
//   TIMER_PAUSE_EN undefined:
//     No pause port; the timer behaves as if pause were tied 0.
// STRUCTURE
//   Shared package maze_game_pkg holds:
//     timer state encoding (IDLE=2'd0, RUNNING=2'd1, EXPIRED=2'd2);
//     the SECONDS_W=7 width constant;
//     the BCD digit type.
//   One sub-module: maze_tick_prescaler (CLOCK_FREQ parameter; enable/clear in; wrap pulse out).
//   The FSM, bonus edge detect, saturating add and BCD split all stay in maze_round_timer.
// TESTING (CLOCK_FREQ=4, ROUND_SECONDS=3, BONUS_SECONDS=2, MAX_SECONDS=5)
//   Pulse start; run 12 cycles -> seconds_left 3,2,1,0 at 4-cycle intervals; timer_end rises with the 0; running falls.
//   Increment mazes_complete mid-round at seconds_left=2 -> 4 next cycle; repeat at 4 -> saturates at 5.
//   Align a bonus with the tick that takes 1->0 -> seconds_left=2, timer_end stays 0.
//   Drive reset=0 for one cycle mid-round -> next cycle all outputs are 0 and state is IDLE.
//     A later mazes_complete change produces no bonus and start is needed to run.
//   In EXPIRED, change mazes_complete -> no effect. Pulse start -> seconds_left=3, timer_end=0.
//   With TIMER_PAUSE_EN: hold pause 10 cycles at seconds_left=2 -> value held, no second_tick.
//     Release -> decrement after 4 further cycles minus the pre-pause prescaler count.
//   Always check seconds_tens/seconds_ones against seconds_left, e.g. 5 -> 0/5; with MAX=99 and 99 -> 9/9.

Source files
------------

// File: rtl/maze_game_pkg.sv
// Shared types for the maze game timer: state encoding,
// seconds width and BCD digit type.
package maze_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_t;

  localparam int SECONDS_W = 7;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/maze_round_timer_if.sv
// Game-side bus for the round timer.
// Optional pause signal exists only with TIMER_PAUSE_EN.
interface maze_round_timer_if;
  import maze_game_pkg::*;

  logic                 start;
  logic [7:0]           mazes_complete;
`ifdef TIMER_PAUSE_EN
  logic                 pause;
`endif
  logic                 timer_end;
  logic                 running;
  logic [SECONDS_W-1:0] seconds_left;
  bcd_t                 seconds_tens;
  bcd_t                 seconds_ones;
  logic                 second_tick;

`ifdef TIMER_PAUSE_EN
  modport master (
    output start, mazes_complete, pause,
    input  timer_end, running, seconds_left,
    input  seconds_tens, seconds_ones, second_tick
  );
  modport slave (
    input  start, mazes_complete, pause,
    output timer_end, running, seconds_left,
    output seconds_tens, seconds_ones, second_tick
  );
`else
  modport master (
    output start, mazes_complete,
    input  timer_end, running, seconds_left,
    input  seconds_tens, seconds_ones, second_tick
  );
  modport slave (
    input  start, mazes_complete,
    output timer_end, running, seconds_left,
    output seconds_tens, seconds_ones, second_tick
  );
`endif

endinterface

// File: rtl/maze_tick_prescaler.sv
// One-second prescaler: counts enabled cycles and
// pulses o_wrap on the cycle it wraps from CLOCK_FREQ-1.
module maze_tick_prescaler #(
  parameter int CLOCK_FREQ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int CW =
    (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [CW-1:0] TC = CW'(CLOCK_FREQ - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_tc;

  assign w_at_tc = (r_cnt == TC);
  assign o_wrap  = i_en && w_at_tc && !i_clr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maze_round_timer.sv
// Per-round countdown timer with maze-completion bonus.
// Define TIMER_PAUSE_EN to add the pause input.
module maze_round_timer
  import maze_game_pkg::*;
#(
  parameter int CLOCK_FREQ    = 50_000_000,
  parameter int ROUND_SECONDS = 60,
  parameter int BONUS_SECONDS = 10,
  parameter int MAX_SECONDS   = 99
) (
  input  logic clock,
  input  logic reset,
  maze_round_timer_if.slave bus
);

  localparam logic [7:0] BONUS8 = 8'(BONUS_SECONDS);
  localparam logic [7:0] MAX8   = 8'(MAX_SECONDS);
  localparam logic [SECONDS_W-1:0] ROUND_S =
    SECONDS_W'(ROUND_SECONDS);
  localparam logic [SECONDS_W-1:0] MAX_S =
    SECONDS_W'(MAX_SECONDS);

  timer_state_t         r_state;
  timer_state_t         w_state_nx;
  logic [SECONDS_W-1:0] r_secs;
  logic [SECONDS_W-1:0] w_secs_nx;
  logic                 r_tick;
  logic                 w_tick_nx;
  logic [7:0]           r_mazes_prev;

  logic                 w_pause;
  logic                 w_bonus;
  logic                 w_en;
  logic                 w_wrap;
  logic [7:0]           w_sum;
  logic [SECONDS_W-1:0] w_sat;

`ifdef TIMER_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  // Any change, including 255->0 wrap, is one bonus
  assign w_bonus = (bus.mazes_complete != r_mazes_prev);
  assign w_en    = (r_state == ST_RUNNING) && !w_pause;

  maze_tick_prescaler #(
    .CLOCK_FREQ(CLOCK_FREQ)
  ) u_presc (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_en),
    .i_clr  (bus.start),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_sum = {1'b0, r_secs} - {7'd0, w_wrap}
          + (w_bonus ? BONUS8 : 8'd0);
    w_sat = (w_sum > MAX8) ? MAX_S : w_sum[SECONDS_W-1:0];
  end

  always_comb begin
    w_state_nx = r_state;
    w_secs_nx  = r_secs;
    w_tick_nx  = 1'b0;
    if (bus.start) begin
      w_state_nx = ST_RUNNING;
      w_secs_nx  = ROUND_S;
    end else if (r_state == ST_RUNNING) begin
      w_tick_nx = w_wrap;
      w_secs_nx = w_sat;
      if (w_sat == '0) begin
        w_state_nx = ST_EXPIRED;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_secs  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_secs  <= w_secs_nx;
      r_tick  <= w_tick_nx;
    end
  end

  // Tracks input even in reset so no bonus fires afterwards
  always_ff @(posedge clock) begin
    r_mazes_prev <= bus.mazes_complete;
  end

  assign bus.timer_end    = (r_state == ST_EXPIRED);
  assign bus.running      = (r_state == ST_RUNNING);
  assign bus.seconds_left = r_secs;
  assign bus.second_tick  = r_tick;
  assign bus.seconds_tens = bcd_t'(r_secs / 7'd10);
  assign bus.seconds_ones = bcd_t'(r_secs % 7'd10);

endmodule

// File: tb/tb_maze_round_timer.sv
// Scoreboard bench for maze_round_timer with a
// second-level reference model; honours TIMER_PAUSE_EN.
module tb_maze_round_timer;

  localparam int CF = 4;
  localparam int RS = 3;
  localparam int BS = 2;
  localparam int MX = 5;
`ifdef TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  typedef struct {
    int te;
    int run;
    int secs;
    int tens;
    int ones;
    int tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_round_timer_if bus();

  maze_round_timer #(
    .CLOCK_FREQ   (CF),
    .ROUND_SECONDS(RS),
    .BONUS_SECONDS(BS),
    .MAX_SECONDS  (MX)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  int         m_st = 0;
  int         m_secs = 0;
  int         m_cyc = 0;
  logic [7:0] m_prev = 8'd0;
  logic [7:0] cur_mz = 8'd250;
  bit         cur_p = 1'b0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Drive one cycle and push the expected post-edge outputs
  task automatic step(bit r, bit s, logic [7:0] mz, bit p);
    exp_t e;
    int   t;
    int   n;
    bit   bonus;
    @(negedge clk);
    rst_n = r;
    bus.start = s;
    bus.mazes_complete = mz;
`ifdef TIMER_PAUSE_EN
    bus.pause = p;
`endif
    t = 0;
    bonus = (mz != m_prev);
    if (!r) begin
      m_st = 0;
      m_secs = 0;
      m_cyc = 0;
    end else if (s) begin
      m_st = 1;
      m_secs = RS;
      m_cyc = 0;
    end else if (m_st == 1) begin
      if (!(PAUSE_EN && p)) begin
        m_cyc += 1;
        if (m_cyc == CF) begin
          t = 1;
          m_cyc = 0;
        end
      end
      n = m_secs - t + (bonus ? BS : 0);
      if (n > MX) n = MX;
      m_secs = n;
      if (n == 0) m_st = 2;
    end
    m_prev = mz;
    e.te   = (m_st == 2) ? 1 : 0;
    e.run  = (m_st == 1) ? 1 : 0;
    e.secs = m_secs;
    e.tens = m_secs / 10;
    e.ones = m_secs % 10;
    e.tick = t;
    q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, cur_mz, cur_p);
  endtask

  task automatic go();
    step(1'b1, 1'b1, cur_mz, cur_p);
  endtask

  task automatic bump();
    cur_mz = cur_mz + 8'd1;
    step(1'b1, 1'b0, cur_mz, cur_p);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("timer_end", int'(bus.timer_end), e.te);
        chk("running", int'(bus.running), e.run);
        chk("seconds_left", int'(bus.seconds_left), e.secs);
        chk("seconds_tens", int'(bus.seconds_tens), e.tens);
        chk("seconds_ones", int'(bus.seconds_ones), e.ones);
        chk("second_tick", int'(bus.second_tick), e.tick);
      end
    end
  end

  initial begin : stim
    bus.start = 1'b0;
    bus.mazes_complete = cur_mz;
`ifdef TIMER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    step(1'b0, 1'b0, cur_mz, 1'b0);
    step(1'b0, 1'b0, cur_mz, 1'b0);
    idle(2);
    // full countdown to expiry
    go();
    idle(14);
    // bonus at 2, then saturation
    go();
    idle(5);
    bump();
    idle(1);
    bump();
    idle(25);
    // bonus aligned with the 1->0 tick
    go();
    idle(11);
    bump();
    idle(3);
    // reset mid-round, then bonus attempt while idle
    go();
    idle(3);
    step(1'b0, 1'b0, cur_mz, cur_p);
    bump();
    idle(6);
    go();
    idle(14);
    // expired: bonus ignored, then restart
    bump();
    idle(2);
    go();
    idle(2);
    go();
    idle(3);
    // 255 -> 0 wrap counts as a bonus
    cur_mz = 8'd255;
    idle(2);
    bump();
    idle(2);
`ifdef TIMER_PAUSE_EN
    go();
    idle(5);
    cur_p = 1'b1;
    idle(10);
    cur_p = 1'b0;
    idle(8);
`endif
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit s;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1)
          cur_mz = cur_mz + 8'd1;
        else
          cur_mz = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) cur_p = ~cur_p;
      step(r, s, cur_mz, cur_p);
    end
    idle(2);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
